// File: rtl/sla_shifter_if.sv
// Handshake and operand bundle for sla_shifter.
// master: the sequencer driving operands and Start.
// slave:  the shifter returning Result/Done/Busy/Overflow.
interface sla_shifter_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Input1;
    logic [WIDTH-1:0] Input2;
    logic [WIDTH-1:0] Result;
    logic             Done;
    logic             Busy;
    logic             Overflow;

    modport master (
        output Start,
        output Input1,
        output Input2,
        input  Result,
        input  Done,
        input  Busy,
        input  Overflow
    );

    modport slave (
        input  Start,
        input  Input1,
        input  Input2,
        output Result,
        output Done,
        output Busy,
        output Overflow
    );
endinterface

// File: rtl/sla_shifter.sv
// Multi-cycle signed arithmetic left shifter, one bit per clock.
// Input1 is shifted left by min(Input2, WIDTH) with zero fill; Overflow is
// sticky per operation and flags any step where the sign bit would change.
// Optional build macro SLA_SATURATE_EN: on overflow, Result saturates to the
// max positive / min negative value according to the sign of Input1.
module sla_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        Reset_n,
    sla_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SLA_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] acc_shl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] amount;
    logic             ovf_acc;
    logic             ovf_acc_next;
    logic             ovf_total;
    logic             step_ovf;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_next;
    logic             ovf_q;
    logic             ovf_next;
`ifdef SLA_SATURATE_EN
    logic             sign_q;
    logic             sign_next;
`endif

    // Clamp the requested shift amount to WIDTH and form the per-step shift/overflow terms.
    always_comb begin
        if (bus.Input2 >= WIDTH_VAL) begin
            amount = CNT_FULL;
        end else begin
            amount = CNT_W'(bus.Input2);
        end
        step_ovf  = acc[WIDTH-1] ^ acc[WIDTH-2];
        acc_shl   = {acc[WIDTH-2:0], 1'b0};
        ovf_total = ovf_acc | step_ovf;
    end

    // Next-state and datapath updates; Result/Overflow load on the edge that enters DONE
    // so they are already valid during the Done cycle and hold afterwards.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        ovf_acc_next = ovf_acc;
        result_next  = result_q;
        ovf_next     = ovf_q;
`ifdef SLA_SATURATE_EN
        sign_next    = sign_q;
`endif
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    acc_next     = bus.Input1;
                    cnt_next     = amount;
                    ovf_acc_next = 1'b0;
`ifdef SLA_SATURATE_EN
                    sign_next    = bus.Input1[WIDTH-1];
`endif
                    if (amount != '0) begin
                        state_next = SHIFT;
                    end else begin
                        state_next  = DONE;
                        result_next = bus.Input1;
                        ovf_next    = 1'b0;
                    end
                end
            end
            SHIFT: begin
                ovf_acc_next = ovf_total;
                acc_next     = acc_shl;
                cnt_next     = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                    ovf_next   = ovf_total;
`ifdef SLA_SATURATE_EN
                    if (ovf_total) begin
                        result_next = sign_q ? MIN_NEG : MAX_POS;
                    end else begin
                        result_next = acc_shl;
                    end
`else
                    result_next = acc_shl;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            ovf_acc  <= ovf_acc_next;
            result_q <= result_next;
            ovf_q    <= ovf_next;
        end
    end

`ifdef SLA_SATURATE_EN
    // Sign of the original operand, captured at Start for saturation.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_next;
        end
    end
`endif

    assign bus.Result   = result_q;
    assign bus.Overflow = ovf_q;
    assign bus.Done     = (state == DONE);
    assign bus.Busy     = (state != IDLE);

    a_done_pulse: assert property (@(posedge clk) disable iff (!Reset_n)
        bus.Done |=> !bus.Done);

    a_done_busy: assert property (@(posedge clk) disable iff (!Reset_n)
        bus.Done |-> bus.Busy);

    a_cnt_range: assert property (@(posedge clk) disable iff (!Reset_n)
        (state == SHIFT) |-> ((cnt != '0) && (cnt <= CNT_FULL)));

endmodule
